// File: rtl/tdm_demux.sv
// Time-division demultiplexer: collects NUM_CH slots per frame from one
// stream and publishes the whole frame atomically with a one-cycle pulse.
module tdm_demux #(
    parameter int NUM_CH = 4,
    parameter int DW     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic                 in_sof,
    input  logic [DW-1:0]        in_data,
    output logic [NUM_CH*DW-1:0] out_data,
    output logic                 out_valid,
    output logic                 out_err
);

    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CW-1:0] LAST = CW'(NUM_CH - 1);

    typedef enum logic {
        IDLE,
        RECV
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          slot_cnt_q, slot_cnt_d;
    logic [NUM_CH*DW-1:0]   cap_q, cap_d;
    logic [NUM_CH*DW-1:0]   out_data_q, out_data_d;
    logic                   out_valid_q, out_valid_d;
    logic                   out_err_q, out_err_d;

    logic                   accept;
    logic [CW-1:0]          idx;
    logic [NUM_CH*DW-1:0]   frame;

    always_comb begin
        state_d     = state_q;
        slot_cnt_d  = slot_cnt_q;
        cap_d       = cap_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        out_err_d   = 1'b0;

        // Non-SOF beats outside a frame are dropped silently.
        accept = in_valid && (in_sof || state_q == RECV);
        idx    = in_sof ? '0 : slot_cnt_q;
        frame  = cap_q;
        frame[int'(idx)*DW +: DW] = in_data;

        if (accept) begin
            cap_d     = frame;
            out_err_d = in_sof && (state_q == RECV);
            if (idx == LAST) begin
                out_data_d  = frame;
                out_valid_d = 1'b1;
                out_err_d   = 1'b0;
                slot_cnt_d  = '0;
                state_d     = IDLE;
            end else begin
                slot_cnt_d = idx + 1'b1;
                state_d    = RECV;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            slot_cnt_q  <= '0;
            cap_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_cnt_q  <= slot_cnt_d;
            cap_q       <= cap_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_err_q   <= out_err_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_err   = out_err_q;

endmodule
